// File: rtl/p3_buf_ctrl_if.sv
// Agent handshake bundle for the packet buffer ownership controller.
// Pulses come from the agents, ownership selects go back to the mux stage.
interface p3_buf_ctrl_if #(
  parameter int IDX_WIDTH = 2
);
  logic                 sn_done;
  logic                 cpu_acc;
  logic                 cpu_rej;
  logic                 fwd_done;
  logic                 sn_rdy;
  logic                 cpu_rdy;
  logic                 fwd_rdy;
  logic [IDX_WIDTH-1:0] sn_sel;
  logic [IDX_WIDTH-1:0] cpu_sel;
  logic [IDX_WIDTH-1:0] fwd_sel;
  logic [IDX_WIDTH-1:0] ping_sel;
  logic [IDX_WIDTH-1:0] pang_sel;
  logic [IDX_WIDTH-1:0] pong_sel;
  logic [IDX_WIDTH-1:0] free_cnt;

  modport master (
    output sn_done, cpu_acc, cpu_rej, fwd_done,
    input  sn_rdy, cpu_rdy, fwd_rdy,
    input  sn_sel, cpu_sel, fwd_sel,
    input  ping_sel, pang_sel, pong_sel,
    input  free_cnt
  );

  modport slave (
    input  sn_done, cpu_acc, cpu_rej, fwd_done,
    output sn_rdy, cpu_rdy, fwd_rdy,
    output sn_sel, cpu_sel, fwd_sel,
    output ping_sel, pang_sel, pong_sel,
    output free_cnt
  );
endinterface

// File: rtl/p3_buf_ctrl.sv
// Ownership controller for the ping/pang/pong packet buffers.
// Snooper fills, CPU filters, forwarder drains, strictly in fill order.
module p3_buf_ctrl #(
  parameter int NUM_BUFS  = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  p3_buf_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_SN,
    ST_READY,
    ST_CPU,
    ST_ACC,
    ST_FWD
  } bst_e;

  typedef logic [IDX_WIDTH-1:0] idx_t;

  bst_e       st_q [NUM_BUFS];
  bst_e       st_d [NUM_BUFS];
  idx_t       rq_q [NUM_BUFS];
  idx_t       rq_d [NUM_BUFS];
  idx_t       aq_q [NUM_BUFS];
  idx_t       aq_d [NUM_BUFS];
  logic [1:0] rq_cnt_q;
  logic [1:0] rq_cnt_d;
  logic [1:0] aq_cnt_q;
  logic [1:0] aq_cnt_d;

  logic sn_own;
  logic cpu_own;
  logic fwd_own;
  idx_t sn_idx;
  idx_t cpu_idx;
  idx_t fwd_idx;
  logic has_empty;
  idx_t emp_idx;
  logic [1:0] free_cnt;

  logic sn_rel;
  logic cpu_rej_v;
  logic cpu_acc_v;
  logic fwd_rel;
  logic sn_gnt;
  logic cpu_gnt;
  logic fwd_gnt;

  idx_t buf_sel [NUM_BUFS];

  // Locate each agent's buffer, the lowest free buffer and the free count.
  always_comb begin
    sn_own    = 1'b0;
    cpu_own   = 1'b0;
    fwd_own   = 1'b0;
    sn_idx    = '0;
    cpu_idx   = '0;
    fwd_idx   = '0;
    has_empty = 1'b0;
    emp_idx   = '0;
    free_cnt  = '0;
    for (int b = NUM_BUFS - 1; b >= 0; b--) begin
      unique case (st_q[b])
        ST_SN: begin
          sn_own = 1'b1;
          sn_idx = idx_t'(b);
        end
        ST_CPU: begin
          cpu_own = 1'b1;
          cpu_idx = idx_t'(b);
        end
        ST_FWD: begin
          fwd_own = 1'b1;
          fwd_idx = idx_t'(b);
        end
        ST_EMPTY: begin
          has_empty = 1'b1;
          emp_idx   = idx_t'(b);
          free_cnt  = free_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Qualify pulses against current ownership; grants need an idle agent.
  always_comb begin
    sn_rel    = sn_own & bus.sn_done;
    cpu_rej_v = cpu_own & bus.cpu_rej;
    cpu_acc_v = cpu_own & bus.cpu_acc & ~bus.cpu_rej;
    fwd_rel   = fwd_own & bus.fwd_done;
    sn_gnt    = ~sn_own & ~bus.sn_done & has_empty;
    cpu_gnt   = ~cpu_own & ~bus.cpu_acc & ~bus.cpu_rej
              & (rq_cnt_q != 2'd0);
    fwd_gnt   = ~fwd_own & ~bus.fwd_done
              & (aq_cnt_q != 2'd0);
  end

  // Next buffer states and queue contents from pre-edge state only.
  always_comb begin
    st_d     = st_q;
    rq_d     = rq_q;
    aq_d     = aq_q;
    rq_cnt_d = rq_cnt_q;
    aq_cnt_d = aq_cnt_q;

    if (sn_rel)
      st_d[sn_idx] = ST_READY;
    if (cpu_rej_v)
      st_d[cpu_idx] = ST_EMPTY;
    else if (cpu_acc_v)
      st_d[cpu_idx] = ST_ACC;
    if (fwd_rel)
      st_d[fwd_idx] = ST_EMPTY;

    if (sn_gnt)
      st_d[emp_idx] = ST_SN;
    if (cpu_gnt)
      st_d[rq_q[0]] = ST_CPU;
    if (fwd_gnt)
      st_d[aq_q[0]] = ST_FWD;

    if (cpu_gnt) begin
      for (int i = 0; i < NUM_BUFS - 1; i++)
        rq_d[i] = rq_q[i+1];
      rq_cnt_d = rq_cnt_q - 2'd1;
    end
    if (sn_rel && (rq_cnt_d < 2'(NUM_BUFS))) begin
      rq_d[rq_cnt_d] = sn_idx;
      rq_cnt_d       = rq_cnt_d + 2'd1;
    end

    if (fwd_gnt) begin
      for (int i = 0; i < NUM_BUFS - 1; i++)
        aq_d[i] = aq_q[i+1];
      aq_cnt_d = aq_cnt_q - 2'd1;
    end
    if (cpu_acc_v && (aq_cnt_d < 2'(NUM_BUFS))) begin
      aq_d[aq_cnt_d] = cpu_idx;
      aq_cnt_d       = aq_cnt_d + 2'd1;
    end
  end

  // State register; reset drops every owner and both queues.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BUFS; b++) begin
        st_q[b] <= ST_EMPTY;
        rq_q[b] <= '0;
        aq_q[b] <= '0;
      end
      rq_cnt_q <= '0;
      aq_cnt_q <= '0;
    end else begin
      st_q     <= st_d;
      rq_q     <= rq_d;
      aq_q     <= aq_d;
      rq_cnt_q <= rq_cnt_d;
      aq_cnt_q <= aq_cnt_d;
    end
  end

  // Per-buffer owner code: 01 snooper, 10 CPU, 11 forwarder.
  always_comb begin
    for (int b = 0; b < NUM_BUFS; b++) begin
      unique case (st_q[b])
        ST_SN:   buf_sel[b] = 2'b01;
        ST_CPU:  buf_sel[b] = 2'b10;
        ST_FWD:  buf_sel[b] = 2'b11;
        default: buf_sel[b] = 2'b00;
      endcase
    end
  end

  // Drive the mux-stage selects straight from registered state.
  always_comb begin
    bus.sn_rdy   = sn_own;
    bus.cpu_rdy  = cpu_own;
    bus.fwd_rdy  = fwd_own;
    bus.sn_sel   = sn_own  ? sn_idx  + 2'd1 : 2'b00;
    bus.cpu_sel  = cpu_own ? cpu_idx + 2'd1 : 2'b00;
    bus.fwd_sel  = fwd_own ? fwd_idx + 2'd1 : 2'b00;
    bus.ping_sel = buf_sel[0];
    bus.pang_sel = buf_sel[1];
    bus.pong_sel = buf_sel[2];
    bus.free_cnt = free_cnt;
  end

endmodule

// File: tb/tb_p3_buf_ctrl.sv
// Bench for the packet buffer ownership controller.
// Vector table through a scoreboard queue, then invariant soak.
module tb_p3_buf_ctrl;

  logic clk;
  logic rst;

  p3_buf_ctrl_if bus ();

  p3_buf_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       sd;
    logic       ca;
    logic       cr;
    logic       fd;
    logic [1:0] sn;
    logic [1:0] cpu;
    logic [1:0] fwd;
    logic [1:0] pi;
    logic [1:0] pa;
    logic [1:0] po;
    logic [1:0] fc;
  } vec_t;

  vec_t vt [$];
  vec_t exp_q [$];

  int checks = 0;
  int errors = 0;
  logic inv_en = 1'b0;

  task automatic add(
    input logic r, sd, ca, cr, fd,
    input logic [1:0] sn, cpu, fwd, pi, pa, po, fc
  );
    vec_t v;
    v = '{r, sd, ca, cr, fd, sn, cpu, fwd, pi, pa, po, fc};
    vt.push_back(v);
  endtask

  task automatic chk(
    input string name, input int idx,
    input logic [1:0] act, input logic [1:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, sd, ca, cr, fd);
    rst         = r;
    bus.sn_done  = sd;
    bus.cpu_acc  = ca;
    bus.cpu_rej  = cr;
    bus.fwd_done = fd;
  endtask

  // Structural invariants every cycle once out of reset.
  always @(negedge clk) begin
    if (inv_en) begin
      logic [1:0] as [1:3];
      logic [1:0] bs [1:3];
      int owned;
      logic bad;
      as[1] = bus.sn_sel;
      as[2] = bus.cpu_sel;
      as[3] = bus.fwd_sel;
      bs[1] = bus.ping_sel;
      bs[2] = bus.pang_sel;
      bs[3] = bus.pong_sel;
      bad = 1'b0;
      owned = 0;
      for (int a = 1; a <= 3; a++) begin
        if (as[a] != 2'd0) begin
          owned++;
          if (bs[int'(as[a])] != 2'(a)) bad = 1'b1;
        end
      end
      for (int b = 1; b <= 3; b++)
        if (bs[b] != 2'd0 && as[int'(bs[b])] != 2'(b)) bad = 1'b1;
      if (as[1] != 0 && (as[1] == as[2] || as[1] == as[3])) bad = 1'b1;
      if (as[2] != 0 && as[2] == as[3]) bad = 1'b1;
      if (bus.sn_rdy  != (as[1] != 0)) bad = 1'b1;
      if (bus.cpu_rdy != (as[2] != 0)) bad = 1'b1;
      if (bus.fwd_rdy != (as[3] != 0)) bad = 1'b1;
      if (int'(bus.free_cnt) > 3 - owned) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL invariant t=%0t: sel sn/cpu/fwd=%0d/%0d/%0d buf=%0d/%0d/%0d free=%0d",
                 $time, as[1], as[2], as[3], bs[1], bs[2], bs[3],
                 bus.free_cnt);
      end
    end
  end

  initial begin
    vec_t v;
    vec_t e;
    int   waited;
    drive(1, 0, 0, 0, 0);

    //   r sd ca cr fd  sn cpu fwd pi pa po fc
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 2, 1, 0, 2, 1, 0, 1);
    add(0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2, 0, 1, 3, 1, 0, 1);
    add(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 2, 0, 1, 2, 0, 1);
    add(0, 1, 0, 0, 0, 0, 2, 0, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 3, 2, 0, 0, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 2, 1, 0, 2, 1, 0, 0);
    add(0, 0, 1, 1, 0, 2, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2, 3, 0, 0, 1, 2, 1);
    add(0, 0, 0, 0, 1, 2, 3, 0, 0, 1, 2, 1);
    add(0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2, 0, 3, 0, 1, 3, 1);
    add(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 3, 1);
    add(0, 0, 0, 0, 0, 1, 2, 3, 1, 2, 3, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2);
    add(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 2);

    foreach (vt[i]) begin
      @(negedge clk);
      v = vt[i];
      drive(v.r, v.sd, v.ca, v.cr, v.fd);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (i == 0) inv_en = 1'b1;
      e = exp_q.pop_front();
      chk("sn_sel",   i, bus.sn_sel,   e.sn);
      chk("cpu_sel",  i, bus.cpu_sel,  e.cpu);
      chk("fwd_sel",  i, bus.fwd_sel,  e.fwd);
      chk("ping_sel", i, bus.ping_sel, e.pi);
      chk("pang_sel", i, bus.pang_sel, e.pa);
      chk("pong_sel", i, bus.pong_sel, e.po);
      chk("free_cnt", i, bus.free_cnt, e.fc);
      chk("rdy", i,
          {bus.sn_rdy, bus.cpu_rdy},
          {e.sn != 2'd0, e.cpu != 2'd0});
    end

    // Random pulse soak: only the invariants judge this stretch.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(0,
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 3) == 0));
    end

    // Mid-run reset, then bounded wait for the first snooper grant.
    @(negedge clk);
    drive(1, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    chk("rst_free", 0, bus.free_cnt, 2'd3);
    chk("rst_sn", 0, bus.sn_sel, 2'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    waited = 0;
    while (!bus.sn_rdy && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (!bus.sn_rdy || waited != 1) begin
      errors++;
      $display("FAIL regrant_latency: got %0d edges rdy=%b want 1 edge",
               waited, bus.sn_rdy);
    end
    chk("regrant_ping", 0, bus.ping_sel, 2'd1);

    @(negedge clk);
    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
